// File: rtl/numeric_code_detonator.sv
// Code-protected detonator controller: keypad code entry/programming, abortable countdown, lockout.
// Latency: state, display and lamps update 1 cycle after the sampled inputs; no backpressure (level commands).
module numeric_code_detonator #(
    parameter logic [15:0] PASSWORD  = 16'h2580,
    parameter int          COUNTDOWN = 5,
    parameter int          MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] A,
    input  logic       setup,
    input  logic       ready,
    input  logic       sure,
    input  logic       fire,
    input  logic       wait_t,
    output logic [3:0] m_disp,
    output logic       lt,
    output logic       rt,
    output logic       bt,
    output logic       lb
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, ENTRY, ARMED, COUNT, BOOM, ERROR, LOCK
    } state_t;

    state_t          state;
    logic [15:0]     code;
    logic [15:0]     dig_buf;
    logic [2:0]      dig_cnt;
    logic [TW-1:0]   tries;
    logic [TW-1:0]   tries_inc;
    logic [9:0]      key_prev;
    logic [3:0]      cnt;
    logic [3:0]      key_dig;
    logic            key_press;

    // A press is a single clean digit that differs from last cycle's keypad value.
    always_comb begin
        key_dig = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (A[i]) key_dig = 4'(i);
        end
        key_press = $onehot(A) && (A != key_prev);
        tries_inc = tries + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            code     <= PASSWORD;
            dig_buf  <= 16'h0;
            dig_cnt  <= 3'd0;
            tries    <= '0;
            key_prev <= 10'h0;
            cnt      <= 4'd0;
            m_disp   <= 4'hF;
        end else begin
            key_prev <= A;
            case (state)
                IDLE: begin
                    if (wait_t) begin
                        m_disp <= 4'hF;
                    end else if (setup || ready) begin
                        state   <= setup ? SETUP : ENTRY;
                        dig_buf <= 16'h0;
                        dig_cnt <= 3'd0;
                        m_disp  <= 4'hF;
                    end
                end
                SETUP: begin
                    if (wait_t) begin
                        state  <= IDLE;
                        m_disp <= 4'hF;
                    end else if (sure && dig_cnt == 3'd4) begin
                        code   <= dig_buf;
                        state  <= IDLE;
                        m_disp <= 4'hF;
                    end else if (key_press) begin
                        dig_buf <= {dig_buf[11:0], key_dig};
                        dig_cnt <= (dig_cnt == 3'd4) ? 3'd4 : dig_cnt + 3'd1;
                        m_disp  <= key_dig;
                    end
                end
                ENTRY: begin
                    if (wait_t) begin
                        state  <= IDLE;
                        m_disp <= 4'hF;
                    end else if (sure) begin
                        if (dig_cnt == 3'd4 && dig_buf == code) begin
                            state  <= ARMED;
                            tries  <= '0;
                            m_disp <= 4'hF;
                        end else begin
                            // Short entries count as wrong codes too.
                            tries  <= tries_inc;
                            state  <= (tries_inc == TW'(MAX_TRIES)) ? LOCK : ERROR;
                            m_disp <= 4'hE;
                        end
                    end else if (key_press) begin
                        dig_buf <= {dig_buf[11:0], key_dig};
                        dig_cnt <= (dig_cnt == 3'd4) ? 3'd4 : dig_cnt + 3'd1;
                        m_disp  <= key_dig;
                    end
                end
                ARMED: begin
                    if (wait_t) begin
                        state  <= IDLE;
                        m_disp <= 4'hF;
                    end else if (fire) begin
                        state  <= COUNT;
                        cnt    <= 4'(COUNTDOWN);
                        m_disp <= 4'(COUNTDOWN);
                    end
                end
                COUNT: begin
                    // Releasing fire or aborting drops back to ARMED, not IDLE.
                    if (fire && !wait_t) begin
                        if (cnt == 4'd0) begin
                            state  <= BOOM;
                            m_disp <= 4'hB;
                        end else begin
                            cnt    <= cnt - 4'd1;
                            m_disp <= cnt - 4'd1;
                        end
                    end else begin
                        state  <= ARMED;
                        m_disp <= 4'hF;
                    end
                end
                ERROR: begin
                    if (wait_t) begin
                        state  <= IDLE;
                        m_disp <= 4'hF;
                    end else if (ready) begin
                        state   <= ENTRY;
                        dig_buf <= 16'h0;
                        dig_cnt <= 3'd0;
                        m_disp  <= 4'hF;
                    end
                end
                BOOM: begin
                    m_disp <= 4'hB;
                end
                LOCK: begin
                    m_disp <= 4'hE;
                end
                default: begin
                    state  <= IDLE;
                    m_disp <= 4'hF;
                end
            endcase
        end
    end

    assign lt = (state == SETUP) || (state == ENTRY);
    assign rt = (state == ARMED) || (state == COUNT);
    assign bt = (state == BOOM);
    assign lb = (state == ERROR) || (state == LOCK);

endmodule

// File: tb/tb_numeric_code_detonator.sv
// Directed bench for numeric_code_detonator: code entry, programming, countdown, abort, error and lockout.
module tb_numeric_code_detonator;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] A;
    logic       setup, ready, sure, fire, wait_t;
    logic [3:0] m_disp;
    logic       lt, rt, bt, lb;
    logic [3:0] lamps;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] L_NONE = 4'b0000;
    localparam logic [3:0] L_LT   = 4'b1000;
    localparam logic [3:0] L_RT   = 4'b0100;
    localparam logic [3:0] L_BT   = 4'b0010;
    localparam logic [3:0] L_LB   = 4'b0001;

    numeric_code_detonator dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .setup  (setup),
        .ready  (ready),
        .sure   (sure),
        .fire   (fire),
        .wait_t (wait_t),
        .m_disp (m_disp),
        .lt     (lt),
        .rt     (rt),
        .bt     (bt),
        .lb     (lb)
    );

    always #5 clk = ~clk;
    assign lamps = {lt, rt, bt, lb};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        A = 10'h0; setup = 0; ready = 0; sure = 0; fire = 0; wait_t = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Press digits MSB-nibble first, one per cycle, then release the keypad.
    task automatic keys(input string tag, input logic [31:0] digs, input int n);
        logic [3:0] d;
        for (int i = n - 1; i >= 0; i--) begin
            d = digs[4*i +: 4];
            A = 10'(1) << d;
            step();
            check_eq({tag, "_disp"}, 32'(m_disp), 32'(d));
        end
        A = 10'h0;
        step();
    endtask

    task automatic pulse_sure();
        sure = 1; step(); sure = 0;
    endtask

    task automatic pulse_ready();
        ready = 1; step(); ready = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        do_reset();
        check_eq("rst_disp", 32'(m_disp), 32'hF);
        check_eq("rst_lamps", 32'(lamps), 32'(L_NONE));

        // Correct code, countdown to detonation.
        pulse_ready();
        check_eq("entry_lamps", 32'(lamps), 32'(L_LT));
        check_eq("entry_disp", 32'(m_disp), 32'hF);
        keys("c2580", 32'h2580, 4);
        A = 10'b0000000011;            // multi-hot ignored
        step();
        check_eq("multihot_disp", 32'(m_disp), 32'h0);
        A = 10'h0;
        step();
        pulse_sure();
        check_eq("armed_lamps", 32'(lamps), 32'(L_RT));
        check_eq("armed_disp", 32'(m_disp), 32'hF);
        fire = 1;
        for (int k = 5; k >= 0; k--) begin
            step();
            check_eq("count_disp", 32'(m_disp), 32'(k));
            check_eq("count_lamps", 32'(lamps), 32'(L_RT));
        end
        step();
        check_eq("boom_lamps", 32'(lamps), 32'(L_BT));
        check_eq("boom_disp", 32'(m_disp), 32'hB);
        fire = 0; wait_t = 1;
        step();
        wait_t = 0;
        check_eq("boom_sticky", 32'(lamps), 32'(L_BT));

        // Wrong code -> ERROR, fire ignored; two more wrong tries -> LOCK.
        do_reset();
        pulse_ready();
        keys("w1", 32'h2581, 4);
        pulse_sure();
        check_eq("err_lamps", 32'(lamps), 32'(L_LB));
        check_eq("err_disp", 32'(m_disp), 32'hE);
        fire = 1;
        repeat (13) step();
        fire = 0;
        check_eq("err_fire_lamps", 32'(lamps), 32'(L_LB));
        check_eq("err_fire_disp", 32'(m_disp), 32'hE);
        pulse_ready();
        check_eq("err_ready", 32'(lamps), 32'(L_LT));
        keys("w2", 32'h1111, 4);
        pulse_sure();
        check_eq("err2_lamps", 32'(lamps), 32'(L_LB));
        pulse_ready();
        keys("w3", 32'h9999, 4);
        pulse_sure();
        check_eq("lock_lamps", 32'(lamps), 32'(L_LB));
        check_eq("lock_disp", 32'(m_disp), 32'hE);
        pulse_ready();
        check_eq("lock_ready_ignored", 32'(lamps), 32'(L_LB));
        do_reset();
        check_eq("unlock_rst_lamps", 32'(lamps), 32'(L_NONE));

        // Program a new code; short sure in SETUP ignored.
        setup = 1; step(); setup = 0;
        check_eq("setup_lamps", 32'(lamps), 32'(L_LT));
        keys("s9", 32'h9, 1);
        pulse_sure();
        check_eq("setup_short_sure", 32'(lamps), 32'(L_LT));
        keys("s1234", 32'h1234, 4);
        pulse_sure();
        check_eq("setup_done_lamps", 32'(lamps), 32'(L_NONE));
        pulse_ready();
        keys("n1234", 32'h1234, 4);
        sure = 1; step(); step(); sure = 0;   // held sure acts once
        check_eq("newcode_armed", 32'(lamps), 32'(L_RT));
        wait_t = 1; step(); wait_t = 0;
        check_eq("armed_abort", 32'(lamps), 32'(L_NONE));
        pulse_ready();
        keys("old2580", 32'h2580, 4);
        pulse_sure();
        check_eq("oldcode_err", 32'(lamps), 32'(L_LB));

        // Reset restores PASSWORD; partial countdown then release.
        do_reset();
        pulse_ready();
        keys("r2580", 32'h2580, 4);
        pulse_sure();
        check_eq("rstcode_armed", 32'(lamps), 32'(L_RT));
        fire = 1;
        repeat (3) step();
        check_eq("partial_disp", 32'(m_disp), 32'h3);
        fire = 0;
        step();
        check_eq("release_lamps", 32'(lamps), 32'(L_RT));
        check_eq("release_disp", 32'(m_disp), 32'hF);
        wait_t = 1; step(); wait_t = 0;
        check_eq("cancel_lamps", 32'(lamps), 32'(L_NONE));

        // Last-4 rule, then short entry.
        pulse_ready();
        keys("five", 32'h92580, 5);
        pulse_sure();
        check_eq("last4_armed", 32'(lamps), 32'(L_RT));
        wait_t = 1; step(); wait_t = 0;
        pulse_ready();
        keys("three", 32'h258, 3);
        pulse_sure();
        check_eq("short_err", 32'(lamps), 32'(L_LB));
        check_eq("short_disp", 32'(m_disp), 32'hE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
